// File: rtl/div.sv
// Multi-cycle 32-bit restoring radix-2 divider for the MIPS execute stage.
// Produces {remainder, quotient} 33 cycles after acceptance; divide-by-zero returns zero.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {S_FREE, S_ON, S_END} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_signed;
    logic        r_sign1;
    logic        r_sign2;
    logic [31:0] r_divisor;
    logic [31:0] r_rem;
    logic [31:0] r_quo;

    logic [32:0] w_trial;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_out;
    logic [31:0] w_rem_out;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] magnitude(input logic sgn, input logic [31:0] v);
        return (sgn && v[31]) ? neg32(v) : v;
    endfunction

    // The remainder never reaches bit 31 on a failed trial (it would have
    // exceeded any 32-bit divisor), so 32 bits of partial remainder suffice.
    always_comb begin
        w_trial = {1'b0, r_rem} + {1'b0, r_rem} + {32'd0, r_quo[31]} - {1'b0, r_divisor};
        if (!w_trial[32]) begin
            w_rem_next = w_trial[31:0];
            w_quo_next = {r_quo[30:0], 1'b1};
        end else begin
            w_rem_next = {r_rem[30:0], r_quo[31]};
            w_quo_next = {r_quo[30:0], 1'b0};
        end
        w_quo_out = (r_signed && (r_sign1 ^ r_sign2)) ? neg32(w_quo_next) : w_quo_next;
        w_rem_out = (r_signed && r_sign1) ? neg32(w_rem_next) : w_rem_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FREE;
            r_cnt     <= 5'd0;
            r_signed  <= 1'b0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_divisor <= 32'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            result_o  <= 64'd0;
            ready_o   <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            r_state  <= S_END;
                            result_o <= 64'd0;
                            ready_o  <= 1'b1;
                        end else begin
                            r_signed  <= signed_div_i;
                            r_sign1   <= opdata1_i[31];
                            r_sign2   <= opdata2_i[31];
                            r_divisor <= magnitude(signed_div_i, opdata2_i);
                            r_quo     <= magnitude(signed_div_i, opdata1_i);
                            r_rem     <= 32'd0;
                            r_cnt     <= 5'd0;
                            r_state   <= S_ON;
                        end
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        r_state  <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state  <= S_END;
                            ready_o  <= 1'b1;
                            result_o <= {w_rem_out, w_quo_out};
                        end
                    end
                end
                S_END: begin
                    // Result is held only while EX keeps requesting it.
                    if (!start_i || annul_i) begin
                        r_state  <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    r_state <= S_FREE;
                end
            endcase
        end
    end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider serving the execute stage of the five-stage MIPS pipeline. It accepts DIV/DIVU operands from EX, iterates one quotient bit per cycle (restoring radix-2), and returns a 64-bit {remainder, quotient} pair. EX holds the pipeline while the divider is busy and forwards the result as the HI/LO write that travels through EX/MEM.

## Interface
Parameters: none. Widths are fixed at 32-bit operands and a 64-bit result.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-low, sampled on the clk rising edge.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- opdata1_i  input  32  dividend; sampled with start_i.
- opdata2_i  input  32  divisor; sampled with start_i.
- start_i  input  1  request; must stay high until ready_o is seen.
- annul_i  input  1  cancel an in-flight or finished division (flush/exception).
- result_o  output  64  [63:32] = remainder (HI), [31:0] = quotient (LO).
- ready_o  output  1  result_o valid.

## Operation
- States: FREE, ON, END.
- Reset (rst=0 at an edge): state←FREE, cnt←0, result_o←0, ready_o←0, internal registers←0. This applies in any state, including mid-division.
- FREE, start_i=1, annul_i=0:
  - opdata2_i=0: state←END, result_o←0, ready_o←1. Divide-by-zero returns zero; no trap.
  - Otherwise: latch signed flag, sign bits op1[31] and op2[31], and operand magnitudes. Magnitude = two's-complement negation when signed and the bit-31 sign is 1, else the raw value. 0x80000000 negates to 0x80000000, which is correct as unsigned.
  - Then r←0 (33 bits), q←|dividend|, cnt←0, state←ON.
- FREE with start_i=0 or annul_i=1: no change; outputs stay 0.
- ON, annul_i=0, one iteration per edge:
  - t = {r[31:0], q[31]} − {1'b0, |divisor|}, computed 33 bits wide.
  - t[32]=0: r←t, q←{q[30:0],1}.
  - t[32]=1: r←{r[31:0],q[31]}, q←{q[30:0],0}.
  - cnt←cnt+1.
- On the edge that performs iteration 32 (cnt=31):
  - state←END, ready_o←1.
  - result_o[31:0] ← q_next negated if signed and op1[31]^op2[31], else q_next.
  - result_o[63:32] ← r_next[31:0] negated if signed and op1[31], else r_next[31:0].
- ON, annul_i=1: state←FREE, ready_o←0, result_o←0. annul_i has priority over iteration.
- END:
  - start_i=1 and annul_i=0: hold result_o and ready_o=1.
  - start_i=0 or annul_i=1: next edge state←FREE, ready_o←0, result_o←0.
- Changes on opdata1_i, opdata2_i or signed_div_i after acceptance have no effect.
- A new request is accepted only from FREE, so back-to-back divisions need at least one cycle with start_i low.

## Timing
- Cycle 0: start_i=1 in FREE; accepted at the end of cycle 0.
- Cycles 1–32: state ON; iterations complete on the edges ending cycles 1..32.
- Cycle 33: ready_o=1, result_o valid. Latency from the start edge is 33 cycles.
- Divide-by-zero: ready_o=1 in cycle 1.
- ready_o and result_o are registered, with no combinational path from inputs.
- Release: start_i low in cycle N (state END) → ready_o=0 in cycle N+1. The earliest next accept is cycle N+1 (FREE).
- Annul asserted in cycle k (ON or END) → state FREE in cycle k+1. ready_o never rises for the annulled operation.

## Test plan
- DIVU 100/7 (0x64/0x7): start at cycle 0 → ready_o rises at cycle 33; result_o = 0x00000002_0000000E. ready_o must stay low in cycles 1–32.
- DIV −7/2 (0xFFFFFFF9/0x00000002) → result_o = 0xFFFFFFFF_FFFFFFFD. DIV 7/−2 → 0x00000001_FFFFFFFD.
- Edge operands:
  - DIV 0x80000000/0xFFFFFFFF → 0x00000000_80000000.
  - DIVU 0xFFFFFFFF/0x00000001 → 0x00000000_FFFFFFFF.
  - DIVU 0x00000003/0x80000000 → 0x00000003_00000000.
- Divide-by-zero: DIVU 5/0 → ready_o=1 and result_o=0 at cycle 1.
- Release: drop start_i in the END state → ready_o=0 next cycle; re-start the following cycle → accepted.
- Abort and reset:
  - annul_i pulse at cycle 10 → FREE at cycle 11; ready_o stays 0; a new DIVU 9/3 then yields 0x00000000_00000003 after 33 cycles.
  - rst=0 at cycle 20 of a division → all outputs 0 next cycle and state FREE. Changing opdata*_i during ON must not alter the result.
